spi_reg_slave: RTL and testbench



---
 rtl/comm_pkg.sv | 29 ++
 rtl/spi_reg_slave_if.sv | 17 +
 rtl/spi_reg_slave_sync_edge.sv | 29 ++
 rtl/spi_reg_slave.sv | 118 +++++++++++
 tb/tb_spi_reg_slave.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/comm_pkg.sv
// Shared SPI definitions: mode encodings, slave FSM states and a constant clog2.
package comm_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,  // CPOL=0 CPHA=0
    SPI_MODE1 = 2'd1,  // CPOL=0 CPHA=1
    SPI_MODE2 = 2'd2,  // CPOL=1 CPHA=0
    SPI_MODE3 = 2'd3   // CPOL=1 CPHA=1
  } spi_mode_e;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } spi_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Sample on rising SCK when CPOL==CPHA, falling otherwise.
  function automatic logic sample_on_rise(input spi_mode_e m);
    return (m == SPI_MODE0) || (m == SPI_MODE3);
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI pins plus parallel register side of the SPI register slave.
interface spi_reg_slave_if #(parameter int DATA_W = 16);
  logic              nss_i;
  logic              sck_i;
  logic              sdi_i;
  logic              sdo_o;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              upd_o;
  logic              err_o;
  logic              busy_o;

  modport slave  (input  nss_i, sck_i, sdi_i, data_i,
                  output sdo_o, data_o, upd_o, err_o, busy_o);
  modport master (output nss_i, sck_i, sdi_i, data_i,
                  input  sdo_o, data_o, upd_o, err_o, busy_o);
endinterface

// File: rtl/spi_reg_slave_sync_edge.sv
// Multi-flop synchroniser with edge detection on the synchronised level.
module sync_edge #(
  parameter int DEPTH   = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [DEPTH-1:0] sync_q;
  logic             prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {DEPTH{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d};
      prev_q <= sync_q[DEPTH-1];
    end
  end

  assign level = sync_q[DEPTH-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/spi_reg_slave.sv
// SPI register slave: shifts a status word out while capturing a control word;
// only frames of exactly DATA_W bits update data_o.
module spi_reg_slave
  import comm_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  spi_reg_slave_if.slave  bus
);
  localparam int             CNT_W       = clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] FLUSH     = CNT_W'(SYNC_STAGES);
  localparam spi_mode_e      MODE        = spi_mode_e'(2'(CPOL * 2 + CPHA));
  localparam bit             SAMPLE_RISE = sample_on_rise(MODE);

  logic nss_lvl, nss_rise, nss_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic sdi_s, sample_edge, shift_edge;

  spi_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] tx, rx;
  logic              fin_ok, fin_bad;

  sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_nss (
    .clk_i(clk_i), .rst_i(rst_i), .d(bus.nss_i),
    .level(nss_lvl), .rise(nss_rise), .fall(nss_fall));

  sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(CPOL != 0)) u_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d(bus.sck_i),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sdi_sync <= '0;
    else       sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi_i};
  end

  assign sdi_s       = sdi_sync[SYNC_STAGES-1];
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= WAIT_IDLE;
      cnt        <= '0;
      tx         <= '0;
      rx         <= '0;
      fin_ok     <= 1'b0;
      fin_bad    <= 1'b0;
      bus.data_o <= '0;
      bus.sdo_o  <= 1'b0;
      bus.upd_o  <= 1'b0;
      bus.err_o  <= 1'b0;
      bus.busy_o <= 1'b0;
    end else begin
      bus.upd_o <= fin_ok;
      bus.err_o <= fin_bad;
      fin_ok    <= 1'b0;
      fin_bad   <= 1'b0;
      if (fin_ok) bus.data_o <= rx;

      case (state)
        // NSS must be seen high for a full synchroniser flush, so the reset
        // value of the chain cannot fake an idle bus mid-frame.
        WAIT_IDLE: begin
          bus.sdo_o  <= 1'b0;
          bus.busy_o <= 1'b0;
          if (!nss_lvl)          cnt <= '0;
          else if (cnt == FLUSH) begin
            cnt   <= '0;
            state <= IDLE;
          end else               cnt <= cnt + CNT_W'(1);
        end
        IDLE: begin
          bus.sdo_o <= 1'b0;
          if (nss_fall) begin
            state      <= SHIFT;
            bus.busy_o <= 1'b1;
            cnt        <= '0;
            if (CPHA != 0) begin
              tx        <= bus.data_i;
              bus.sdo_o <= 1'b0;
            end else begin
              tx        <= {bus.data_i[DATA_W-2:0], 1'b0};
              bus.sdo_o <= bus.data_i[DATA_W-1];
            end
          end
        end
        SHIFT: begin
          if (nss_rise) begin
            state      <= IDLE;
            bus.busy_o <= 1'b0;
            bus.sdo_o  <= 1'b0;
            fin_ok     <= (cnt == CNT_FULL);
            fin_bad    <= (cnt != CNT_FULL);
          end else begin
            if (sample_edge) begin
              rx <= {rx[DATA_W-2:0], sdi_s};
              if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            end
            if (shift_edge) begin
              bus.sdo_o <= tx[DATA_W-1];
              tx        <= {tx[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench: one slave per SPI mode, driven by a bit-banged master.
module tb_spi_reg_slave;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       nss = 4'hF;
  logic [3:0]       sck = 4'b1100;
  logic [3:0]       sdi = 4'h0;
  logic [3:0][15:0] din = '0;
  logic [3:0]       sdo, upd, err, busy;
  logic [3:0][15:0] dout;

  for (genvar g = 0; g < 4; g++) begin : m
    spi_reg_slave_if #(.DATA_W(16)) bus ();
    assign bus.nss_i  = nss[g];
    assign bus.sck_i  = sck[g];
    assign bus.sdi_i  = sdi[g];
    assign bus.data_i = din[g];
    assign sdo[g]     = bus.sdo_o;
    assign dout[g]    = bus.data_o;
    assign upd[g]     = bus.upd_o;
    assign err[g]     = bus.err_o;
    assign busy[g]    = bus.busy_o;
    spi_reg_slave #(.DATA_W(16), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus));
  end

  int upd_cnt [4] = '{0, 0, 0, 0};
  int err_cnt [4] = '{0, 0, 0, 0};
  int both_cnt = 0;
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (upd[g]) upd_cnt[g]++;
      if (err[g]) err_cnt[g]++;
      if (upd[g] && err[g]) both_cnt++;
    end
  end

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bits(input int md, input logic [31:0] word, input int nbits,
                           output logic [31:0] miso);
    logic cpol, cpha;
    cpol = (md >= 2);
    cpha = (md % 2 == 1);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        sdi[md] = word[nbits-1-i];
        #HALF;
        miso = {miso[30:0], sdo[md]};
        sck[md] = ~cpol;
        #HALF;
        sck[md] = cpol;
      end else begin
        sck[md] = ~cpol;
        sdi[md] = word[nbits-1-i];
        #HALF;
        miso = {miso[30:0], sdo[md]};
        sck[md] = cpol;
        #HALF;
      end
    end
  endtask

  task automatic run_frame(input int md, input logic [31:0] word, input int nbits,
                           input logic [15:0] d, output logic [31:0] miso);
    din[md] = d;
    nss[md] = 1'b0;
    #HALF;
    send_bits(md, word, nbits, miso);
    #HALF;
    nss[md] = 1'b1;
    #(HALF * 3);
  endtask

  typedef struct {
    string       name;
    int          mode;
    logic [31:0] mosi;
    int          nbits;
    logic [15:0] din;
    logic [15:0] exp_data;
    logic [31:0] exp_miso;
    int          exp_upd;
    int          exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] miso, m1, m2;
    int u0, e0, n;
    bit seen;

    vecs[0] = '{"m0_ok",    0, 32'h1234,  16, 16'hA55A, 16'h1234, 32'hA55A,  1, 0};
    vecs[1] = '{"m1_ok",    1, 32'hBEEF,  16, 16'h0F0F, 16'hBEEF, 32'h0F0F,  1, 0};
    vecs[2] = '{"m2_ok",    2, 32'hBEEF,  16, 16'h0F0F, 16'hBEEF, 32'h0F0F,  1, 0};
    vecs[3] = '{"m3_ok",    3, 32'hBEEF,  16, 16'h0F0F, 16'hBEEF, 32'h0F0F,  1, 0};
    vecs[4] = '{"m0_short", 0, 32'h2AAA,  15, 16'hA55A, 16'h1234, 32'h52AD,  0, 1};
    vecs[5] = '{"m0_long",  0, 32'h1FFFF, 17, 16'hA55A, 16'h1234, 32'h14AB4, 0, 1};
    vecs[6] = '{"m1_short", 1, 32'h7FFF,  15, 16'h0F0F, 16'hBEEF, 32'h0787,  0, 1};
    vecs[7] = '{"m3_zero",  3, 32'h0000,  16, 16'hFFFF, 16'h0000, 32'hFFFF,  1, 0};

    // Reset state, observed while reset is still asserted.
    repeat (2) @(negedge clk);
    check("rst_data", 32'(dout[0]), 32'h0);
    check("rst_sdo",  32'(sdo),     32'h0);
    check("rst_busy", 32'(busy),    32'h0);
    check("rst_upd",  32'(upd),     32'h0);
    check("rst_err",  32'(err),     32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      u0 = upd_cnt[vecs[i].mode];
      e0 = err_cnt[vecs[i].mode];
      run_frame(vecs[i].mode, vecs[i].mosi, vecs[i].nbits, vecs[i].din, miso);
      check({vecs[i].name, "_data"}, 32'(dout[vecs[i].mode]), 32'(vecs[i].exp_data));
      check({vecs[i].name, "_miso"}, miso, vecs[i].exp_miso);
      check({vecs[i].name, "_upd"},  32'(upd_cnt[vecs[i].mode] - u0), 32'(vecs[i].exp_upd));
      check({vecs[i].name, "_err"},  32'(err_cnt[vecs[i].mode] - e0), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_idle"}, 32'({busy[vecs[i].mode], sdo[vecs[i].mode]}), 32'h0);
    end

    // data_i changes mid-frame; MISO must carry the snapshot. Also NSS->upd latency.
    u0 = upd_cnt[0];
    din[0] = 16'h0001;
    nss[0] = 1'b0;
    #HALF;
    send_bits(0, 32'hC3, 8, m1);
    check("snap_busy", 32'(busy[0]), 32'h1);
    din[0] = 16'h8000;
    send_bits(0, 32'hC3, 8, m2);
    #HALF;
    @(negedge clk);
    nss[0] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      seen = upd[0];
    end
    check("upd_latency", 32'(n), 32'd4);
    #(HALF * 3);
    check("snap_miso", {m1[7:0], m2[7:0]}, 32'h0001);
    check("snap_data", 32'(dout[0]), 32'hC3C3);
    check("snap_upd",  32'(upd_cnt[0] - u0), 32'd1);

    // Reset mid-frame with NSS held low: remainder of that frame is silent.
    u0 = upd_cnt[0];
    e0 = err_cnt[0];
    din[0] = 16'h0000;
    nss[0] = 1'b0;
    #HALF;
    send_bits(0, 32'hFF, 8, m1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_bits(0, 32'hFF, 8, m2);
    #HALF;
    nss[0] = 1'b1;
    #(HALF * 3);
    check("rstmid_upd",  32'(upd_cnt[0] - u0), 32'd0);
    check("rstmid_err",  32'(err_cnt[0] - e0), 32'd0);
    check("rstmid_data", 32'(dout[0]), 32'h0);
    u0 = upd_cnt[0];
    run_frame(0, 32'h5555, 16, 16'h0000, miso);
    check("after_rst_data", 32'(dout[0]), 32'h5555);
    check("after_rst_upd",  32'(upd_cnt[0] - u0), 32'd1);

    check("upd_err_overlap", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
